// File: rtl/acumulador_muestras.sv
// -----------------------------------------------------------------------------
// acumulador_muestras
//
// Purpose:
//   Sums N_MUESTRAS unsigned 7-bit sensor samples into a 9-bit measurement
//   result for the downstream alarm classifier. A measurement is requested
//   with `start`, samples are accepted with a valid/ready handshake while the
//   block is accumulating, and the finished sum is presented with sel=0 until
//   the next measurement is requested.
//
// Ports:
//   clk         in   1  single clock, rising-edge active
//   rst         in   1  asynchronous, active-high reset
//   start       in   1  request a new measurement (honoured in IDLE and LISTO)
//   dato        in   7  unsigned sensor sample
//   dato_valid  in   1  dato is valid this cycle
//   dato_ready  out  1  block accepts a sample this cycle (state ACUM)
//   sum         out  9  measurement result, held until the next completion
//   sel         out  1  0 = sum valid and stable, 1 = not valid
//   done        out  1  one-cycle pulse when a measurement completes
//   busy        out  1  high while accumulating
//   timeout     out  1  one-cycle pulse on watchdog abort (0 without watchdog)
//
// Parameters:
//   N_MUESTRAS      samples per measurement, legal 1..4
//   TIMEOUT_CICLOS  consecutive cycles without a transfer before abort
//
// Configuration macro:
//   ACUM_TIMEOUT_EN  when defined, a watchdog aborts a stalled measurement
//                    after TIMEOUT_CICLOS cycles without a transfer. When
//                    undefined the block waits in ACUM indefinitely and
//                    timeout is tied low.
// -----------------------------------------------------------------------------
module acumulador_muestras #(
    parameter int N_MUESTRAS     = 4,
    parameter int TIMEOUT_CICLOS = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] dato,
    input  logic       dato_valid,
    output logic       dato_ready,
    output logic [8:0] sum,
    output logic       sel,
    output logic       done,
    output logic       busy,
    output logic       timeout
);

    // Elaboration-time guards on the parameter ranges.
    if ((N_MUESTRAS < 1) || (N_MUESTRAS > 4)) begin : g_n_muestras_fuera_rango
        $error("acumulador_muestras: N_MUESTRAS must be in 1..4");
    end
    if (TIMEOUT_CICLOS < 1) begin : g_timeout_fuera_rango
        $error("acumulador_muestras: TIMEOUT_CICLOS must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACUM  = 2'd1,
        LISTO = 2'd2
    } estado_t;

    // Counter value seen on the edge that carries the final sample.
    localparam logic [2:0] ULTIMA = 3'(N_MUESTRAS - 1);

    estado_t    estado;
    logic [8:0] acc;        // running sum of the current measurement
    logic [2:0] cnt;        // samples accepted so far in this measurement
    logic       transfer;   // handshake completes on this edge
    logic [8:0] acc_next;   // accumulator including the sample on the bus

    // Worst case 4*127 = 508 fits in 9 bits, so no carry handling is needed.
    assign transfer = (estado == ACUM) && dato_valid;
    assign acc_next = acc + {2'b00, dato};

    // Handshake and status flags are pure decodes of the registered state.
    assign dato_ready = (estado == ACUM);
    assign busy       = (estado == ACUM);
    assign sel        = (estado != LISTO);

`ifdef ACUM_TIMEOUT_EN
    localparam int              WD_W   = $clog2(TIMEOUT_CICLOS + 1);
    localparam logic [WD_W-1:0] WD_FIN = WD_W'(TIMEOUT_CICLOS - 1);

    logic [WD_W-1:0] wd;         // consecutive ACUM cycles without a transfer
    logic            timeout_r;

    assign timeout = timeout_r;
`else
    assign timeout = 1'b0;
`endif

    // Measurement FSM: state, accumulator, sample counter and result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado    <= IDLE;
            acc       <= 9'd0;
            cnt       <= 3'd0;
            sum       <= 9'd0;
            done      <= 1'b0;
`ifdef ACUM_TIMEOUT_EN
            wd        <= '0;
            timeout_r <= 1'b0;
`endif
        end else begin
            // Pulses default low; only the completing/aborting edge raises them.
            done      <= 1'b0;
`ifdef ACUM_TIMEOUT_EN
            timeout_r <= 1'b0;
`endif
            case (estado)
                IDLE: begin
                    acc <= 9'd0;
                    cnt <= 3'd0;
`ifdef ACUM_TIMEOUT_EN
                    wd  <= '0;
`endif
                    if (start) begin
                        estado <= ACUM;
                    end else begin
                        estado <= IDLE;
                    end
                end

                ACUM: begin
                    // start is deliberately not examined here: a request
                    // during accumulation must not disturb the measurement.
                    if (transfer) begin
                        acc <= acc_next;
                        cnt <= cnt + 3'd1;
`ifdef ACUM_TIMEOUT_EN
                        wd  <= '0;
`endif
                        if (cnt == ULTIMA) begin
                            estado <= LISTO;
                            sum    <= acc_next;
                            done   <= 1'b1;
                        end else begin
                            estado <= ACUM;
                        end
                    end else begin
`ifdef ACUM_TIMEOUT_EN
                        // Abort on the cycle that completes the idle run;
                        // the previous result in sum is left untouched.
                        if (wd == WD_FIN) begin
                            estado    <= IDLE;
                            timeout_r <= 1'b1;
                            wd        <= '0;
                        end else begin
                            estado    <= ACUM;
                            wd        <= wd + {{(WD_W-1){1'b0}}, 1'b1};
                        end
`else
                        estado <= ACUM;
`endif
                    end
                end

                LISTO: begin
                    // A new request restarts from a clean accumulator while
                    // sum keeps the previous result until the next completion.
                    if (start) begin
                        estado <= ACUM;
                        acc    <= 9'd0;
                        cnt    <= 3'd0;
`ifdef ACUM_TIMEOUT_EN
                        wd     <= '0;
`endif
                    end else begin
                        estado <= LISTO;
                    end
                end

                default: begin
                    estado <= IDLE;
                    acc    <= 9'd0;
                    cnt    <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acumulador_muestras.sv
// -----------------------------------------------------------------------------
// tb_acumulador_muestras
//
// Self-checking bench for acumulador_muestras. A reference model kept as a
// queue of accepted samples predicts the outputs after every clock edge; the
// directed scenarios add explicit checks against hand-computed constants.
// -----------------------------------------------------------------------------
module tb_acumulador_muestras;

    localparam int N  = 4;
    localparam int TO = 8;
`ifdef ACUM_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       start;
    logic [6:0] dato;
    logic       dato_valid;
    logic       dato_ready;
    logic [8:0] sum;
    logic       sel;
    logic       done;
    logic       busy;
    logic       timeout;

    int vectors;
    int miscompares;

    // Reference model state
    bit         m_meas;       // a measurement is in progress
    bit         m_result_ok;  // sum holds a valid result (sel expected 0)
    bit         m_done;
    bit         m_timeout;
    logic [8:0] m_sum;
    int         m_idle;
    int         m_samples[$];

    acumulador_muestras #(
        .N_MUESTRAS     (N),
        .TIMEOUT_CICLOS (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dato       (dato),
        .dato_valid (dato_valid),
        .dato_ready (dato_ready),
        .sum        (sum),
        .sel        (sel),
        .done       (done),
        .busy       (busy),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {dato_ready, busy, sel, done, timeout, sum}
    function automatic logic [13:0] modelo_salidas();
        return {m_meas, m_meas, ~m_result_ok, m_done, m_timeout, m_sum};
    endfunction

    function automatic logic [13:0] dut_salidas();
        return {dato_ready, busy, sel, done, timeout, sum};
    endfunction

    task automatic modelo_reset();
        m_meas      = 1'b0;
        m_result_ok = 1'b0;
        m_done      = 1'b0;
        m_timeout   = 1'b0;
        m_sum       = 9'd0;
        m_idle      = 0;
        m_samples.delete();
    endtask

    // Drive one cycle of stimulus, advance the model, sample #1 after the edge.
    task automatic step(input logic s, input logic v, input logic [6:0] d);
        int total;
        start      = s;
        dato_valid = v;
        dato       = d;
        m_done     = 1'b0;
        m_timeout  = 1'b0;
        if (m_meas) begin
            if (v) begin
                m_samples.push_back(int'(d));
                m_idle = 0;
                if (m_samples.size() == N) begin
                    total = 0;
                    foreach (m_samples[i]) total += m_samples[i];
                    m_sum       = 9'(total);
                    m_meas      = 1'b0;
                    m_result_ok = 1'b1;
                    m_done      = 1'b1;
                end
            end else begin
                m_idle++;
                if (TO_EN && (m_idle == TO)) begin
                    m_meas    = 1'b0;
                    m_timeout = 1'b1;
                end
            end
        end else if (s) begin
            m_meas      = 1'b1;
            m_result_ok = 1'b0;
            m_idle      = 0;
            m_samples.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        start      = 1'b0;
        dato_valid = 1'b0;
        dato       = 7'd0;
        modelo_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (dut_salidas() !== 14'b00100_000000000) begin
            miscompares++;
            $display("FAIL reset_state: got %h expected %h", dut_salidas(), 14'b00100_000000000);
        end
        rst = 1'b0;
        step(1'b0, 1'b0, 7'd0);
        vectors++;
        if (dut_salidas() !== modelo_salidas()) begin
            miscompares++;
            $display("FAIL reset_idle: got %h expected %h", dut_salidas(), modelo_salidas());
        end
    endtask

    task automatic test_back_to_back();
        step(1'b1, 1'b0, 7'd0);
        vectors++;
        if (dut_salidas() !== modelo_salidas()) begin
            miscompares++;
            $display("FAIL b2b_start: got %h expected %h", dut_salidas(), modelo_salidas());
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 7'(10 * (i + 1)));
            vectors++;
            if (dut_salidas() !== modelo_salidas()) begin
                miscompares++;
                $display("FAIL b2b_sample%0d: got %h expected %h", i, dut_salidas(), modelo_salidas());
            end
        end
        vectors++;
        if ({done, sel, sum} !== {1'b1, 1'b0, 9'd100}) begin
            miscompares++;
            $display("FAIL b2b_result: got done=%b sel=%b sum=%0d expected done=1 sel=0 sum=100", done, sel, sum);
        end
        step(1'b0, 1'b0, 7'd0);
        vectors++;
        if ({done, sel, sum} !== {1'b0, 1'b0, 9'd100}) begin
            miscompares++;
            $display("FAIL b2b_hold: got done=%b sel=%b sum=%0d expected done=0 sel=0 sum=100", done, sel, sum);
        end
    endtask

    task automatic test_gaps();
        int n_done;
        n_done = 0;
        step(1'b1, 1'b0, 7'd0);
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < 3; g++) begin
                step(1'b0, (g == 2), 7'd127);
                if (done === 1'b1) n_done++;
                vectors++;
                if (dut_salidas() !== modelo_salidas()) begin
                    miscompares++;
                    $display("FAIL gaps_s%0d_c%0d: got %h expected %h", i, g, dut_salidas(), modelo_salidas());
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 7'd127);
            if (done === 1'b1) n_done++;
        end
        vectors++;
        if ({sum, dato_ready, sel} !== {9'd508, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL gaps_result: got sum=%0d ready=%b sel=%b expected sum=508 ready=0 sel=0", sum, dato_ready, sel);
        end
        vectors++;
        if (n_done !== 1) begin
            miscompares++;
            $display("FAIL gaps_done_count: got %0d expected 1", n_done);
        end
    endtask

    task automatic test_restart_from_listo();
        step(1'b1, 1'b0, 7'd0);
        vectors++;
        if ({sel, busy, sum} !== {1'b1, 1'b1, 9'd508}) begin
            miscompares++;
            $display("FAIL restart_enter: got sel=%b busy=%b sum=%0d expected sel=1 busy=1 sum=508", sel, busy, sum);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 7'd1);
            vectors++;
            if (dut_salidas() !== modelo_salidas()) begin
                miscompares++;
                $display("FAIL restart_sample%0d: got %h expected %h", i, dut_salidas(), modelo_salidas());
            end
        end
        vectors++;
        if ({sum, sel, done} !== {9'd4, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL restart_result: got sum=%0d sel=%b done=%b expected sum=4 sel=0 done=1", sum, sel, done);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b0, 7'd0);
        step(1'b0, 1'b1, 7'd3);
        step(1'b0, 1'b1, 7'd3);
        // Assert reset between edges; outputs must change with no clock edge.
        rst = 1'b1;
        #2;
        vectors++;
        if (dut_salidas() !== 14'b00100_000000000) begin
            miscompares++;
            $display("FAIL reset_async: got %h expected %h", dut_salidas(), 14'b00100_000000000);
        end
        modelo_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b1, 1'b0, 7'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 7'd5);
            vectors++;
            if (dut_salidas() !== modelo_salidas()) begin
                miscompares++;
                $display("FAIL reset_mid_sample%0d: got %h expected %h", i, dut_salidas(), modelo_salidas());
            end
        end
        vectors++;
        if (sum !== 9'd20) begin
            miscompares++;
            $display("FAIL reset_mid_result: got %0d expected 20", sum);
        end
    endtask

    task automatic test_ignored_inputs();
        // dato_valid in LISTO must not disturb anything.
        step(1'b0, 1'b1, 7'd99);
        vectors++;
        if (dut_salidas() !== modelo_salidas()) begin
            miscompares++;
            $display("FAIL ignore_listo: got %h expected %h", dut_salidas(), modelo_salidas());
        end
        rst = 1'b1;
        modelo_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 7'd50);
            vectors++;
            if (dut_salidas() !== modelo_salidas()) begin
                miscompares++;
                $display("FAIL ignore_idle%0d: got %h expected %h", i, dut_salidas(), modelo_salidas());
            end
        end
        step(1'b1, 1'b1, 7'd77);   // sample alongside start in IDLE is dropped
        step(1'b0, 1'b1, 7'd2);
        step(1'b1, 1'b1, 7'd3);    // start mid-ACUM ignored, sample counted
        step(1'b1, 1'b0, 7'd0);
        vectors++;
        if (dut_salidas() !== modelo_salidas()) begin
            miscompares++;
            $display("FAIL ignore_start_acum: got %h expected %h", dut_salidas(), modelo_salidas());
        end
        step(1'b0, 1'b1, 7'd4);
        step(1'b0, 1'b1, 7'd5);
        vectors++;
        if ({sum, done} !== {9'd14, 1'b1}) begin
            miscompares++;
            $display("FAIL ignore_result: got sum=%0d done=%b expected sum=14 done=1", sum, done);
        end
    endtask

    task automatic test_random();
        logic s;
        logic v;
        for (int i = 0; i < 400; i++) begin
            s = ($urandom_range(0, 7) == 0);
            v = ($urandom_range(0, 2) != 0);
            step(s, v, 7'($urandom_range(0, 127)));
            vectors++;
            if (dut_salidas() !== modelo_salidas()) begin
                miscompares++;
                $display("FAIL random_cycle%0d: got %h expected %h", i, dut_salidas(), modelo_salidas());
            end
        end
    endtask

`ifdef ACUM_TIMEOUT_EN
    task automatic test_timeout();
        logic [8:0] sum_prev;
        int         n_done;
        n_done = 0;
        sum_prev = m_sum;
        step(1'b1, 1'b0, 7'd0);
        step(1'b0, 1'b1, 7'd9);
        for (int i = 0; i < TO; i++) begin
            step(1'b0, 1'b0, 7'd0);
            if (done === 1'b1) n_done++;
            vectors++;
            if (dut_salidas() !== modelo_salidas()) begin
                miscompares++;
                $display("FAIL timeout_cycle%0d: got %h expected %h", i, dut_salidas(), modelo_salidas());
            end
        end
        vectors++;
        if ({timeout, busy, sel, sum, n_done} !== {1'b1, 1'b0, 1'b1, sum_prev, 32'd0}) begin
            miscompares++;
            $display("FAIL timeout_abort: got to=%b busy=%b sel=%b sum=%0d dones=%0d expected to=1 busy=0 sel=1 sum=%0d dones=0",
                     timeout, busy, sel, sum, n_done, sum_prev);
        end
        step(1'b0, 1'b0, 7'd0);
        vectors++;
        if (timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_pulse: got %b expected 0", timeout);
        end
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_back_to_back();
        test_gaps();
        test_restart_from_listo();
        test_reset_mid();
        test_ignored_inputs();
        test_random();
`ifdef ACUM_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/acumulador_muestras.md
ACUMULADOR_MUESTRAS -- requirements
Module: acumulador_muestras

Interface
REQ-001 Parameter: N_MUESTRAS, default 4, number of samples summed per measurement; legal range 1..4.
REQ-002 Parameter: TIMEOUT_CICLOS, default 255, idle cycles in ACUM before abort; only used when ACUM_TIMEOUT_EN is defined.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: start  input  1  request a new measurement.
REQ-006 Port: dato  input  7  unsigned sensor sample.
REQ-007 Port: dato_valid  input  1  dato is valid this cycle.
REQ-008 Port: dato_ready  output  1  block accepts a sample this cycle.
REQ-009 Port: sum  output  9  unsigned measurement result; feeds the alarm classifier.
REQ-010 Port: sel  output  1  0 = sum valid and stable for the alarm stage; 1 = not valid.
REQ-011 Port: done  output  1  one-cycle pulse when a measurement completes.
REQ-012 Port: busy  output  1  high while in ACUM.
REQ-013 Port: timeout  output  1  one-cycle pulse on abort; constant 0 without ACUM_TIMEOUT_EN.

Function
REQ-014 FSM states: IDLE, ACUM, LISTO; all outputs registered or decoded from state only.
REQ-015 IDLE: dato_ready=0, busy=0, sel=1; start=1 -> ACUM next cycle; internal accumulator and sample counter cleared to 0.
REQ-016 ACUM: dato_ready=1, busy=1, sel=1; transfer occurs on an edge where dato_valid=1 and dato_ready=1.
REQ-017 Each transfer: accumulator += zero-extended dato (9 bits); counter += 1.
REQ-018 Transfer number N_MUESTRAS: next cycle state=LISTO, sum=final accumulator, done=1 for exactly one cycle.
REQ-019 Latency: sum valid and sel=0 in the cycle after the last transfer; minimum N_MUESTRAS+1 cycles from start to done with dato_valid held high.
REQ-020 Arithmetic: maximum 4*127=508 < 512; no overflow or saturation logic.
REQ-021 LISTO: dato_ready=0, busy=0, sel=0, sum held constant; start=1 -> ACUM, sel=1 next cycle, sum holds last value until next completion.
REQ-022 start while in ACUM is ignored; measurement continues unchanged.
REQ-023 dato_valid while not in ACUM is ignored; no accumulation.
REQ-024 dato_valid gaps in ACUM stall the measurement without changing accumulator or counter.

Reset
REQ-025 rst=1 forces, immediately and asynchronously: state=IDLE, sum=0, sel=1, done=0, busy=0, dato_ready=0, timeout=0, accumulator=0, counter=0.
REQ-026 Reset mid-measurement discards partial accumulation; no done pulse is produced.
REQ-027 After rst deasserts, block waits in IDLE for start.

Configuration
REQ-028 Macro ACUM_TIMEOUT_EN defined: a watchdog counter runs in ACUM, clears on each transfer and on entry to ACUM; upon reaching TIMEOUT_CICLOS consecutive cycles without transfer -> IDLE, timeout=1 for one cycle, sum unchanged, sel=1, no done.
REQ-029 ACUM_TIMEOUT_EN undefined: no watchdog logic; ACUM waits indefinitely; timeout tied 0.

Verification
REQ-030 start, then samples 10,20,30,40 back-to-back -> done pulse 1 cycle after 4th transfer, sum=100, sel=0.
REQ-031 start, four samples of 127 with 2-cycle dato_valid gaps -> sum=508, done exactly once, dato_ready low after completion.
REQ-032 start in LISTO, then samples 1,1,1,1 -> sel=1 during ACUM, sum holds previous value until done, then sum=4.
REQ-033 rst asserted after 2 transfers -> outputs at reset values asynchronously; new start plus samples 5,5,5,5 -> sum=20.
REQ-034 start asserted again mid-ACUM and dato_valid pulsed in IDLE -> no effect on count or sum.
REQ-035 With ACUM_TIMEOUT_EN, TIMEOUT_CICLOS=8: start, one sample, then no dato_valid -> timeout pulse after 8 idle cycles, state IDLE, sum unchanged, done never asserted.
